// File: rtl/run_sequencer_if.sv
// Run request/acknowledge bundle between the bench and run_sequencer.
// The bench drives Req; the sequencer reports run status back.
interface run_sequencer_if #(
  parameter int CW = 16
);
  logic          Req;
  logic          Ack;
  logic          TimedOut;
  logic          Busy;
  logic [CW-1:0] CycleCount;

  modport master (
    output Req,
    input  Ack,
    input  TimedOut,
    input  CycleCount,
    input  Busy
  );

  modport slave (
    input  Req,
    output Ack,
    output TimedOut,
    output CycleCount,
    output Busy
  );
endinterface

// File: rtl/run_sequencer.sv
// Run controller: clears a DataMem window, pulses core reset,
// then times the core run until done or watchdog expiry.
module run_sequencer #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int CLR_BASE  = 128,
  parameter int CLR_COUNT = 16,
  parameter int CW        = 16,
  parameter int TIMEOUT   = 4000
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          CoreDone,
  output logic          CoreReset,
  output logic          MemSel,
  output logic [AW-1:0] MemAddr,
  output logic          MemWrEn,
  output logic [DW-1:0] MemWrData,
  run_sequencer_if.slave bus
);

  localparam int IW =
    (CLR_COUNT > 1) ? $clog2(CLR_COUNT) : 1;

  localparam logic [IW-1:0] IDX_LAST =
    IW'((CLR_COUNT > 0) ? CLR_COUNT - 1 : 0);

  localparam logic [AW-1:0] BASE = AW'(CLR_BASE);

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            to_q, to_d;

  // State, clear index, cycle counter and timeout flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Next-state: run sequencing, abort on Req drop, watchdog
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Req) begin
          cnt_d = '0;
          to_d  = 1'b0;
          idx_d = '0;
          state_d = (CLR_COUNT > 0) ? S_CLEAR : S_START;
        end
      end
      S_CLEAR: begin
        if (!bus.Req) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = S_START;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_START: begin
        state_d = bus.Req ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (!bus.Req) begin
          state_d = S_IDLE;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          // Done beats a coincident watchdog expiry
          if (CoreDone) begin
            state_d = S_DONE;
            to_d    = 1'b0;
          end else if (cnt_q >= TO_LAST) begin
            state_d = S_DONE;
            to_d    = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!bus.Req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state and registered counters only
  always_comb begin
    CoreReset      = 1'b1;
    MemSel         = 1'b0;
    MemWrEn        = 1'b0;
    MemAddr        = '0;
    MemWrData      = '0;
    bus.Ack        = 1'b0;
    bus.Busy       = 1'b0;
    bus.TimedOut   = to_q;
    bus.CycleCount = cnt_q;
    unique case (state_q)
      S_CLEAR: begin
        MemSel   = 1'b1;
        MemWrEn  = 1'b1;
        MemAddr  = BASE + AW'(idx_q);
        bus.Busy = 1'b1;
      end
      S_START: begin
        bus.Busy = 1'b1;
      end
      S_RUN: begin
        CoreReset = 1'b0;
        bus.Busy  = 1'b1;
      end
      S_DONE: begin
        bus.Ack = 1'b1;
      end
      default: begin
        CoreReset = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: directed runs with queued
// expectations checked by independent write/ack monitors.
module tb_run_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic       cd_a = 1'b0, cd_b = 1'b0;
  logic       cr_a, ms_a, we_a;
  logic       cr_b, ms_b, we_b;
  logic [7:0] ad_a, wd_a, ad_b, wd_b;

  run_sequencer_if #(.CW(16)) bus_a ();
  run_sequencer_if #(.CW(16)) bus_b ();

  run_sequencer #(
    .AW(8), .DW(8), .CLR_BASE(128), .CLR_COUNT(16),
    .CW(16), .TIMEOUT(100)
  ) dut_a (
    .Clk(clk), .Reset(rst), .CoreDone(cd_a),
    .CoreReset(cr_a), .MemSel(ms_a), .MemAddr(ad_a),
    .MemWrEn(we_a), .MemWrData(wd_a), .bus(bus_a.slave)
  );

  run_sequencer #(
    .AW(8), .DW(8), .CLR_BASE(250), .CLR_COUNT(10),
    .CW(16), .TIMEOUT(100)
  ) dut_b (
    .Clk(clk), .Reset(rst), .CoreDone(cd_b),
    .CoreReset(cr_b), .MemSel(ms_b), .MemAddr(ad_b),
    .MemWrEn(we_b), .MemWrData(wd_b), .bus(bus_b.slave)
  );

  logic [7:0]  exp_wr_a[$], exp_wr_b[$];
  logic [16:0] exp_ack_a[$], exp_ack_b[$];
  logic        ack_prev_a = 1'b0, ack_prev_b = 1'b0;
  logic [7:0]  ew_a, ew_b;
  logic [16:0] ea_a, ea_b;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor A: every clear write and every Ack rise
  always @(negedge clk) begin
    if (we_a) begin
      if (exp_wr_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_a_extra: got addr %0d required none", ad_a);
      end else begin
        ew_a = exp_wr_a.pop_front();
        chk("wr_a_addr", 32'(ad_a), 32'(ew_a));
        chk("wr_a_data", 32'(wd_a), 0);
        chk("wr_a_sel", 32'(ms_a), 1);
        chk("wr_a_corerst", 32'(cr_a), 1);
      end
    end
    if (bus_a.Ack && !ack_prev_a) begin
      if (exp_ack_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL ack_a_extra: got Ack 1 required 0");
      end else begin
        ea_a = exp_ack_a.pop_front();
        chk("ack_a_timedout", 32'(bus_a.TimedOut), 32'(ea_a[16]));
        chk("ack_a_count", 32'(bus_a.CycleCount), 32'(ea_a[15:0]));
      end
    end
    ack_prev_a = bus_a.Ack;
  end

  // Monitor B: every clear write and every Ack rise
  always @(negedge clk) begin
    if (we_b) begin
      if (exp_wr_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_b_extra: got addr %0d required none", ad_b);
      end else begin
        ew_b = exp_wr_b.pop_front();
        chk("wr_b_addr", 32'(ad_b), 32'(ew_b));
        chk("wr_b_data", 32'(wd_b), 0);
      end
    end
    if (bus_b.Ack && !ack_prev_b) begin
      if (exp_ack_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL ack_b_extra: got Ack 1 required 0");
      end else begin
        ea_b = exp_ack_b.pop_front();
        chk("ack_b_timedout", 32'(bus_b.TimedOut), 32'(ea_b[16]));
        chk("ack_b_count", 32'(bus_b.CycleCount), 32'(ea_b[15:0]));
      end
    end
    ack_prev_b = bus_b.Ack;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "bench timeout");
  end

  task automatic push_a16();
    for (int i = 0; i < 16; i++) exp_wr_a.push_back(8'(128 + i));
  endtask

  initial begin
    int k;
    bus_a.Req = 1'b0;
    bus_b.Req = 1'b0;
    rst = 1'b1;
    tick(3);
    chk("rst_corerst", 32'(cr_a), 1);
    chk("rst_ack", 32'(bus_a.Ack), 0);
    chk("rst_busy", 32'(bus_a.Busy), 0);
    chk("rst_memsel", 32'(ms_a), 0);
    chk("rst_wren", 32'(we_a), 0);
    chk("rst_count", 32'(bus_a.CycleCount), 0);
    chk("rst_timedout", 32'(bus_a.TimedOut), 0);
    chk("rst_corerst_b", 32'(cr_b), 1);
    rst = 1'b0;

    // 16 clear writes, CoreReset falls on edge 18
    push_a16();
    bus_a.Req = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick(1);
      chk("t1_corerst", 32'(cr_a), (e >= 18) ? 0 : 1);
    end
    chk("t1_busy", 32'(bus_a.Busy), 1);

    // CoreDone on RUN cycle 50 (edge 68)
    tick(47);
    exp_ack_a.push_back({1'b0, 16'd50});
    cd_a = 1'b1;
    tick(1);
    cd_a = 1'b0;
    chk("t2_ack", 32'(bus_a.Ack), 1);

    // Req held through DONE: no restart, CoreDone ignored
    cd_a = 1'b1;
    tick(5);
    cd_a = 1'b0;
    chk("t6_ack_held", 32'(bus_a.Ack), 1);
    chk("t6_busy", 32'(bus_a.Busy), 0);
    chk("t6_count_hold", 32'(bus_a.CycleCount), 50);
    chk("t6_corerst", 32'(cr_a), 1);
    bus_a.Req = 1'b0;
    tick(1);
    chk("t2_ack_fall", 32'(bus_a.Ack), 0);
    chk("t2_idle_busy", 32'(bus_a.Busy), 0);
    chk("t2_idle_corerst", 32'(cr_a), 1);

    // New run after one low cycle; watchdog at 100
    push_a16();
    exp_ack_a.push_back({1'b1, 16'd100});
    bus_a.Req = 1'b1;
    tick(1);
    chk("t6_count_restart", 32'(bus_a.CycleCount), 0);
    chk("t6_to_restart", 32'(bus_a.TimedOut), 0);
    k = 1;
    while (!bus_a.Ack && k < 400) begin
      tick(1);
      k++;
    end
    chk("t3_timeout_edge", k, 118);
    bus_a.Req = 1'b0;
    tick(1);

    // CoreDone coincident with watchdog expiry
    push_a16();
    exp_ack_a.push_back({1'b0, 16'd100});
    bus_a.Req = 1'b1;
    tick(117);
    cd_a = 1'b1;
    tick(1);
    cd_a = 1'b0;
    chk("t3_tie_ack", 32'(bus_a.Ack), 1);
    bus_a.Req = 1'b0;
    tick(1);

    // Abort on RUN cycle 20
    push_a16();
    bus_a.Req = 1'b1;
    tick(37);
    chk("t5_running", 32'(cr_a), 0);
    bus_a.Req = 1'b0;
    tick(1);
    chk("t5_abort_busy", 32'(bus_a.Busy), 0);
    chk("t5_abort_corerst", 32'(cr_a), 1);
    chk("t5_abort_ack", 32'(bus_a.Ack), 0);
    tick(3);
    chk("t5_abort_ack_later", 32'(bus_a.Ack), 0);

    // Reset during CLEAR after 5 writes
    for (int i = 0; i < 5; i++) exp_wr_a.push_back(8'(128 + i));
    bus_a.Req = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(1);
    chk("t5_rst_wren", 32'(we_a), 0);
    chk("t5_rst_corerst", 32'(cr_a), 1);
    chk("t5_rst_memsel", 32'(ms_a), 0);
    rst = 1'b0;
    bus_a.Req = 1'b0;
    tick(2);

    // Wrapping clear window 250..255, 0..3
    for (int i = 0; i < 10; i++) exp_wr_b.push_back(8'(250 + i));
    exp_ack_b.push_back({1'b0, 16'd1});
    bus_b.Req = 1'b1;
    tick(1);
    k = 1;
    while (cr_b && k < 100) begin
      tick(1);
      k++;
    end
    chk("t4_corerst_latency", k, 12);
    cd_b = 1'b1;
    tick(1);
    cd_b = 1'b0;
    chk("t4_ack", 32'(bus_b.Ack), 1);
    bus_b.Req = 1'b0;
    tick(2);

    chk("wr_a_drained", exp_wr_a.size(), 0);
    chk("wr_b_drained", exp_wr_b.size(), 0);
    chk("ack_a_drained", exp_ack_a.size(), 0);
    chk("ack_b_drained", exp_ack_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
